axi_img_loader: RTL and testbench
=================================

Name: axi_img_loader

Overview:
- AXI4 initiator that fills a program memory from a byte stream (UART RX or JTAG bridge), then releases the core.
- Sits on the instruction-memory slave port ahead of the core's fetch master.
- Packs bytes into 32-bit words and issues single-beat AXI writes to the memory responder.
- Asserts `done_o`, which the top level uses as the core's `start_fetch_i`.

Parameters:
- BASE_ADDR, 'h8000_0000, AXI byte address of the first word. Must be 4-byte aligned.
- MAX_BYTES, 65536, largest accepted image in bytes. The length header is checked against it.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- byte_valid_i  in  1  input byte present
- byte_data_i  in  8  input byte
- byte_ready_o  out  1  loader accepts the byte this cycle
- axi_mosi_o  out  s_axi_mosi_t  AXI initiator request channels
- axi_miso_i  in  s_axi_miso_t  AXI responder channels
- done_o  out  1  image fully written and acknowledged (sticky)
- error_o  out  1  oversize header or non-OKAY BRESP (sticky)
- words_o  out  32  count of words acknowledged via B

Behaviour:
- Reset (`rst` sampled high at a `clk` edge):
  - state=HDR; all counters 0.
  - `byte_ready_o`=0, `done_o`=0, `error_o`=0, `words_o`=0.
  - All `axi_mosi_o` fields 0.
  - Reset mid-transaction abandons the transfer immediately. Memory is reset together with the loader.
- Stream format:
  - 4-byte little-endian length N (bytes), then N payload bytes.
  - Payload is packed little-endian: byte k of a word goes to bits [8k+7:8k].
- Byte handshake: a byte transfers when `byte_valid_i` && `byte_ready_o`. `byte_ready_o`=1 only in HDR and DATA.
- HDR:
  - Collect 4 bytes into the length register.
  - On the 4th byte: if N==0 go to DONE; if N>MAX_BYTES go to ERROR; otherwise go to DATA.
- DATA:
  - Collect bytes into the word buffer and count them in `rem` (starts at N).
  - Go to AXI_WR when 4 bytes are collected, or when the last payload byte arrives.
  - Partial last word: unfilled bytes are 0 and their WSTRB bits are 0. Example: N=6, last word WSTRB=4'b0011.
- AXI_WR:
  - AW and W are driven in the same cycle, starting the cycle after entry. AWVALID and WVALID are asserted together.
  - AW fields: AWADDR=BASE_ADDR+4*word_idx (32-bit modulo), AWLEN=0, AWSIZE=3'b010, AWBURST=INCR, AWID=0.
  - W fields: WDATA=word, WSTRB per above, WLAST=1.
  - Each VALID drops the cycle after its own handshake. AW and W may complete in either order or together.
  - AWADDR, WDATA and WSTRB hold stable while the corresponding VALID is high.
  - Go to AXI_B once both handshakes are done.
- AXI_B:
  - BREADY=1. On BVALID: word_idx++, `words_o`++.
  - BRESP!=OKAY goes to ERROR.
  - If all N bytes are done go to DONE; otherwise go to DATA.
  - BVALID arriving in AXI_WR is ignored; BREADY=0 there.
- DONE: `done_o`=1 permanently until reset; `byte_ready_o`=0.
- ERROR: `error_o`=1 permanently until reset; `byte_ready_o`=0; `done_o` stays 0.
- Read channels are never used: ARVALID=0, RREADY=0.
- Only one outstanding write at a time. Throughput is bounded by the slave's AW/W/B latency.
- `word_idx` width is $clog2(MAX_BYTES/4)+1. The address sum wraps at 2^32; no error is raised on wrap.

Decomposition:
- Add to `utils_pkg`:
  - AXI constants: AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY, if not already present.
  - `ldr_st_t` enum {HDR, DATA, AXI_WR, AXI_B, DONE, ERROR}.
- No sub-module; byte packing and the FSM share counters, so the block is a single module.
- The testbench reuses `axi_mem` as the responder.

Test Plan:
1. Header N=8, payload 11..18 (hex), `axi_mem` slave → writes 0x14131211 @0x8000_0000 and 0x18171615 @0x8000_0004, both WSTRB=4'hF; `words_o`=2; `done_o`=1; read-back matches.
2. N=6, payload 01..06 → second write WDATA=0x00000605, WSTRB=4'b0011 @0x8000_0004; `done_o`=1.
3. N=0 → no AW/W transfer ever; `done_o`=1 the cycle after the 4th header byte.
4. Header N=MAX_BYTES+4 → `error_o`=1, `byte_ready_o`=0, no AXI valid ever asserted, `done_o`=0.
5. Responder delays AWREADY 3 cycles while WREADY=1 immediately, then returns BRESP=SLVERR → WVALID drops after 1 cycle; AWADDR stable for 4 cycles; `error_o`=1; `words_o`=1.
6. `rst` pulsed while in AXI_WR with AWVALID=1 → next cycle all outputs 0, state HDR; a fresh N=4 image completes normally.

Source files
------------

// File: rtl/axi_img_loader_pkg.sv
// Shared types and constants for the image loader: AXI channel bundles,
// AXI encodings and the loader state enumeration.
package axi_img_loader_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        HDR    = 3'd0,
        DATA   = 3'd1,
        AXI_WR = 3'd2,
        AXI_B  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } ldr_st_t;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } s_axi_miso_t;

    // Byte-lane strobe for a word whose highest filled lane is last_lane.
    function automatic logic [3:0] strb_for(input logic [1:0] last_lane);
        logic [3:0] s;
        case (last_lane)
            2'd0:    s = 4'b0001;
            2'd1:    s = 4'b0011;
            2'd2:    s = 4'b0111;
            2'd3:    s = 4'b1111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/axi_img_loader_if.sv
// AXI4 write-side bundle between the loader (master) and the memory (slave).
interface axi_img_loader_if;
    import axi_img_loader_pkg::*;

    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    modport master (output mosi, input miso);
    modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_img_loader.sv
// Streams a length-prefixed byte image into memory via single-beat AXI
// writes, then raises a sticky done flag that releases the core's fetch.
module axi_img_loader
    import axi_img_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MAX_BYTES = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_data_i,
    output logic                    byte_ready_o,
    axi_img_loader_if.master        axi,
    output logic                    done_o,
    output logic                    error_o,
    output logic [31:0]             words_o
);

    localparam int IDX_W = $clog2(MAX_BYTES / 4) + 1;

    ldr_st_t            state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        words_q, words_d;
    s_axi_mosi_t        mosi_q, mosi_d;
    logic               byte_ready_q, byte_ready_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               byte_xfer_s;
    logic [31:0]        hdr_len_s;
    logic [31:0]        word_nxt_s;
    logic               aw_done_s;
    logic               w_done_s;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HDR;
            len_q        <= 32'd0;
            hdr_cnt_q    <= 2'd0;
            rem_q        <= 32'd0;
            word_q       <= 32'd0;
            bcnt_q       <= 2'd0;
            idx_q        <= '0;
            words_q      <= 32'd0;
            mosi_q       <= '0;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hdr_cnt_q    <= hdr_cnt_d;
            rem_q        <= rem_d;
            word_q       <= word_d;
            bcnt_q       <= bcnt_d;
            idx_q        <= idx_d;
            words_q      <= words_d;
            mosi_q       <= mosi_d;
            byte_ready_q <= byte_ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic: header parsing, byte packing and the AXI write sequence.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hdr_cnt_d   = hdr_cnt_q;
        rem_d       = rem_q;
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        idx_d       = idx_q;
        words_d     = words_q;
        mosi_d      = mosi_q;
        byte_xfer_s = byte_valid_i && byte_ready_q;
        hdr_len_s   = {byte_data_i, len_q[31:8]};
        word_nxt_s  = word_q | (32'(byte_data_i) << {bcnt_q, 3'b000});
        aw_done_s   = !mosi_q.awvalid || axi.miso.awready;
        w_done_s    = !mosi_q.wvalid || axi.miso.wready;

        case (state_q)
            HDR: begin
                if (byte_xfer_s) begin
                    len_d     = hdr_len_s;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    rem_d     = hdr_len_s;
                    if (hdr_cnt_q != 2'd3) begin
                        state_d = HDR;
                    end else if (hdr_len_s == 32'd0) begin
                        state_d = DONE;
                    end else if (hdr_len_s > 32'(MAX_BYTES)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            DATA: begin
                if (byte_xfer_s) begin
                    rem_d  = rem_q - 32'd1;
                    word_d = word_nxt_s;
                    bcnt_d = bcnt_q + 2'd1;
                    // A full word or the final payload byte launches the write.
                    if ((bcnt_q == 2'd3) || (rem_q == 32'd1)) begin
                        state_d        = AXI_WR;
                        word_d         = 32'd0;
                        bcnt_d         = 2'd0;
                        mosi_d.awid    = 4'd0;
                        mosi_d.awaddr  = BASE_ADDR + 32'({idx_q, 2'b00});
                        mosi_d.awlen   = 8'd0;
                        mosi_d.awsize  = AXI_SIZE_4B;
                        mosi_d.awburst = AXI_BURST_INCR;
                        mosi_d.awvalid = 1'b1;
                        mosi_d.wdata   = word_nxt_s;
                        mosi_d.wstrb   = strb_for(bcnt_q);
                        mosi_d.wlast   = 1'b1;
                        mosi_d.wvalid  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            AXI_WR: begin
                mosi_d.awvalid = mosi_q.awvalid && !axi.miso.awready;
                mosi_d.wvalid  = mosi_q.wvalid && !axi.miso.wready;
                if (aw_done_s && w_done_s) begin
                    state_d       = AXI_B;
                    mosi_d.bready = 1'b1;
                end else begin
                    state_d = AXI_WR;
                end
            end
            AXI_B: begin
                if (axi.miso.bvalid) begin
                    mosi_d.bready = 1'b0;
                    idx_d         = idx_q + 1'b1;
                    words_d       = words_q + 32'd1;
                    if (axi.miso.bresp != AXI_RESP_OKAY) begin
                        state_d = ERROR;
                    end else if (rem_q == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = AXI_B;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        mosi_d.arvalid = 1'b0;
        mosi_d.rready  = 1'b0;
        byte_ready_d   = (state_d == HDR) || (state_d == DATA);
        done_d         = (state_d == DONE);
        error_d        = (state_d == ERROR);
    end

    assign axi.mosi     = mosi_q;
    assign byte_ready_o = byte_ready_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_axi_img_loader.sv
// Directed bench for axi_img_loader with a behavioural AXI memory responder.
module tb_axi_img_loader;
    import axi_img_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] words_o;

    axi_img_loader_if axi ();

    axi_img_loader #(.BASE_ADDR(32'h8000_0000), .MAX_BYTES(65536)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .axi          (axi),
        .done_o       (done_o),
        .error_o      (error_o),
        .words_o      (words_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          aw_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;

    int          aw_cnt;
    logic        got_aw, got_w, bvalid_r, prev_awv, any_valid, addr_changed;
    logic [1:0]  bresp_r;
    logic [31:0] cap_addr, cap_data, prev_addr;
    logic [3:0]  cap_strb;
    int          aw_hi, w_hi;
    logic [31:0] mem [0:15];
    logic [31:0] aw_log [$];
    logic [31:0] wd_log [$];
    logic [3:0]  ws_log [$];

    always_comb begin
        axi.miso         = '0;
        axi.miso.awready = axi.mosi.awvalid && (aw_cnt == aw_delay);
        axi.miso.wready  = axi.mosi.wvalid;
        axi.miso.bvalid  = bvalid_r;
        axi.miso.bresp   = bresp_r;
    end

    // Memory responder plus channel monitor; cleared with the loader's reset.
    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; bvalid_r <= 1'b0;
            bresp_r <= 2'b00; prev_awv <= 1'b0; any_valid <= 1'b0;
            addr_changed <= 1'b0; aw_hi <= 0; w_hi <= 0;
            aw_log.delete(); wd_log.delete(); ws_log.delete();
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else begin
            prev_awv  <= axi.mosi.awvalid;
            prev_addr <= axi.mosi.awaddr;
            if (axi.mosi.awvalid || axi.mosi.wvalid || axi.mosi.arvalid) any_valid <= 1'b1;
            if (axi.mosi.awvalid && prev_awv && (axi.mosi.awaddr != prev_addr)) addr_changed <= 1'b1;
            if (axi.mosi.awvalid) aw_hi <= aw_hi + 1;
            if (axi.mosi.wvalid) w_hi <= w_hi + 1;
            if (axi.mosi.awvalid && axi.miso.awready) begin
                aw_log.push_back(axi.mosi.awaddr);
                got_aw <= 1'b1; cap_addr <= axi.mosi.awaddr; aw_cnt <= 0;
            end else if (axi.mosi.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axi.mosi.wvalid && axi.miso.wready) begin
                wd_log.push_back(axi.mosi.wdata);
                ws_log.push_back(axi.mosi.wstrb);
                got_w <= 1'b1; cap_data <= axi.mosi.wdata; cap_strb <= axi.mosi.wstrb;
            end
            if (bvalid_r && axi.mosi.bready) begin
                bvalid_r <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            end else if (got_aw && got_w && !bvalid_r) begin
                for (int k = 0; k < 4; k++)
                    if (cap_strb[k]) mem[cap_addr[5:2]][8*k +: 8] <= cap_data[8*k +: 8];
                bvalid_r <= 1'b1;
                bresp_r  <= bresp_cfg;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        @(negedge clk);
        while (!byte_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("byte_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic wait_flag(input string tag, input bit want_err);
        int n = 0;
        while (((want_err ? error_o : done_o) !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(want_err ? error_o : done_o), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_ready", 32'(byte_ready_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_words", words_o, 32'd0);
        chk("rst_mosi_zero", 32'(axi.mosi != '0), 32'd0);
        rst = 1'b0;

        // 1: two full words
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        wait_flag("t1_done", 1'b0);
        chk("t1_aw_count", 32'(aw_log.size()), 32'd2);
        if (aw_log.size() == 2 && wd_log.size() == 2) begin
            chk("t1_addr0", aw_log[0], 32'h8000_0000);
            chk("t1_addr1", aw_log[1], 32'h8000_0004);
            chk("t1_data0", wd_log[0], 32'h1413_1211);
            chk("t1_data1", wd_log[1], 32'h1817_1615);
            chk("t1_strb0", 32'(ws_log[0]), 32'hF);
            chk("t1_strb1", 32'(ws_log[1]), 32'hF);
        end
        chk("t1_words", words_o, 32'd2);
        chk("t1_mem0", mem[0], 32'h1413_1211);
        chk("t1_mem1", mem[1], 32'h1817_1615);
        chk("t1_error", 32'(error_o), 32'd0);

        // 2: partial last word
        do_reset();
        send_hdr(32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'h01 + 8'(i));
        wait_flag("t2_done", 1'b0);
        chk("t2_aw_count", 32'(aw_log.size()), 32'd2);
        if (aw_log.size() == 2 && wd_log.size() == 2) begin
            chk("t2_addr1", aw_log[1], 32'h8000_0004);
            chk("t2_data0", wd_log[0], 32'h0403_0201);
            chk("t2_data1", wd_log[1], 32'h0000_0605);
            chk("t2_strb1", 32'(ws_log[1]), 32'h3);
        end
        chk("t2_mem1", mem[1], 32'h0000_0605);
        chk("t2_words", words_o, 32'd2);

        // 3: empty image
        do_reset();
        send_hdr(32'd0);
        chk("t3_done_next", 32'(done_o), 32'd1);
        chk("t3_ready", 32'(byte_ready_o), 32'd0);
        repeat (5) @(posedge clk); #1;
        chk("t3_no_valid", 32'(any_valid), 32'd0);
        chk("t3_words", words_o, 32'd0);

        // 4: oversize header
        do_reset();
        send_hdr(32'd65540);
        chk("t4_error", 32'(error_o), 32'd1);
        chk("t4_ready", 32'(byte_ready_o), 32'd0);
        repeat (5) @(posedge clk); #1;
        chk("t4_no_valid", 32'(any_valid), 32'd0);
        chk("t4_done", 32'(done_o), 32'd0);

        // 5: slow AWREADY, SLVERR response
        do_reset();
        aw_delay  = 3;
        bresp_cfg = 2'b10;
        send_hdr(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        wait_flag("t5_error", 1'b1);
        chk("t5_w_cycles", 32'(w_hi), 32'd1);
        chk("t5_aw_cycles", 32'(aw_hi), 32'd4);
        chk("t5_addr_stable", 32'(addr_changed), 32'd0);
        chk("t5_words", words_o, 32'd1);
        chk("t5_done", 32'(done_o), 32'd0);

        // 6: reset while AWVALID is held, then a clean image
        do_reset();
        aw_delay  = 8;
        bresp_cfg = 2'b00;
        send_hdr(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        @(negedge clk);
        chk("t6_awvalid", 32'(axi.mosi.awvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_mosi_zero", 32'(axi.mosi != '0), 32'd0);
        chk("t6_ready", 32'(byte_ready_o), 32'd0);
        chk("t6_words", words_o, 32'd0);
        chk("t6_flags", {30'd0, done_o, error_o}, 32'd0);
        rst = 1'b0;
        aw_delay = 0;
        @(posedge clk); #1;
        chk("t6_ready_hdr", 32'(byte_ready_o), 32'd1);
        send_hdr(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
        wait_flag("t6_done", 1'b0);
        chk("t6_mem0", mem[0], 32'h2423_2221);
        chk("t6_words_after", words_o, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
